// File: rtl/dmem_arb_if.sv
// dmem_arb_if: CPU port, host port and dmem port bundle for the data-memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arb_if;
   logic        C_REQ;
   logic [31:2] C_ADDR;
   logic [31:0] C_WDATA;
   logic [3:0]  C_WSTB;
   logic        C_GNT;
   logic        C_STALL;
   logic [31:0] C_RDATA;
   logic        C_RVALID;

   logic        H_REQ;
   logic [31:2] H_ADDR;
   logic [31:0] H_WDATA;
   logic [3:0]  H_WSTB;
   logic        H_GNT;
   logic [31:0] H_RDATA;
   logic        H_RVALID;

   logic        M_CE;
   logic [31:2] M_ADDR;
   logic [31:0] M_DATAO;
   logic [3:0]  M_WSTB;
   logic [31:0] M_DATAI;

   modport slave (
      input  C_REQ, C_ADDR, C_WDATA, C_WSTB,
      input  H_REQ, H_ADDR, H_WDATA, H_WSTB,
      input  M_DATAI,
      output C_GNT, C_STALL, C_RDATA, C_RVALID,
      output H_GNT, H_RDATA, H_RVALID,
      output M_CE, M_ADDR, M_DATAO, M_WSTB
   );

   modport master (
      output C_REQ, C_ADDR, C_WDATA, C_WSTB,
      output H_REQ, H_ADDR, H_WDATA, H_WSTB,
      output M_DATAI,
      input  C_GNT, C_STALL, C_RDATA, C_RVALID,
      input  H_GNT, H_RDATA, H_RVALID,
      input  M_CE, M_ADDR, M_DATAO, M_WSTB
   );
endinterface

// File: rtl/dmem_arb.sv
// dmem_arb: single-cycle arbiter giving the CPU and host ports shared access to a
// 1-cycle-latency data memory; round-robin or CPU priority with bounded host wait.
module dmem_arb #(
   parameter int unsigned PRIO_MODE = 0,
   parameter int unsigned MAX_WAIT  = 8
) (
   input  logic      CLK,
   input  logic      RSTN,
   dmem_arb_if.slave bus
);
   typedef enum logic {LG_CPU = 1'b0, LG_HOST = 1'b1} lg_t;

   localparam logic [7:0] W_MAX = 8'(MAX_WAIT);

   lg_t        r_lg;
   logic [7:0] r_wcnt;
   logic       r_c_rvalid;
   logic       r_h_rvalid;

   logic       w_both;
   logic       w_c_gnt;
   logic       w_h_gnt;

   // Grants are forced low while in reset so nothing reaches dmem.
   always_comb begin
      w_both  = bus.C_REQ & bus.H_REQ;
      w_c_gnt = 1'b0;
      w_h_gnt = 1'b0;
      if (RSTN) begin
         if (w_both) begin
            if (PRIO_MODE == 0) w_h_gnt = (r_lg == LG_CPU);
            else                w_h_gnt = (r_wcnt == W_MAX);
            w_c_gnt = ~w_h_gnt;
         end else begin
            w_c_gnt = bus.C_REQ;
            w_h_gnt = bus.H_REQ;
         end
      end
   end

   always_comb begin
      bus.M_ADDR  = '0;
      bus.M_DATAO = '0;
      bus.M_WSTB  = '0;
      if (w_c_gnt) begin
         bus.M_ADDR  = bus.C_ADDR;
         bus.M_DATAO = bus.C_WDATA;
         bus.M_WSTB  = bus.C_WSTB;
      end else if (w_h_gnt) begin
         bus.M_ADDR  = bus.H_ADDR;
         bus.M_DATAO = bus.H_WDATA;
         bus.M_WSTB  = bus.H_WSTB;
      end
   end

   assign bus.M_CE     = w_c_gnt | w_h_gnt;
   assign bus.C_GNT    = w_c_gnt;
   assign bus.H_GNT    = w_h_gnt;
   assign bus.C_STALL  = bus.C_REQ & ~w_c_gnt;
   assign bus.C_RVALID = r_c_rvalid;
   assign bus.H_RVALID = r_h_rvalid;
   assign bus.C_RDATA  = r_c_rvalid ? bus.M_DATAI : '0;
   assign bus.H_RDATA  = r_h_rvalid ? bus.M_DATAI : '0;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_lg       <= LG_HOST;
         r_wcnt     <= '0;
         r_c_rvalid <= 1'b0;
         r_h_rvalid <= 1'b0;
      end else begin
         if (w_c_gnt)      r_lg <= LG_CPU;
         else if (w_h_gnt) r_lg <= LG_HOST;

         if (bus.H_REQ && !w_h_gnt) begin
            if (r_wcnt < W_MAX) r_wcnt <= r_wcnt + 8'd1;
         end else begin
            r_wcnt <= '0;
         end

         r_c_rvalid <= w_c_gnt && (bus.C_WSTB == 4'b0000);
         r_h_rvalid <= w_h_gnt && (bus.H_WSTB == 4'b0000);
      end
   end
endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter PRIO_MODE, default 0; 0 = round-robin, 1 = CPU fixed priority with host anti-starvation.
REQ-002 SHALL have parameter MAX_WAIT, default 8; host wait-cycle limit in PRIO_MODE 1, range 1..255.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RSTN, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port C_REQ, input, 1, CPU data-port request.
REQ-006 SHALL have port C_ADDR, input, [31:2], CPU word address.
REQ-007 SHALL have port C_WDATA, input, 32, CPU write data.
REQ-008 SHALL have port C_WSTB, input, 4, CPU byte write strobes; 0000 = read.
REQ-009 SHALL have port C_GNT, output, 1, CPU request accepted this cycle.
REQ-010 SHALL have port C_STALL, output, 1, equal to C_REQ & ~C_GNT.
REQ-011 SHALL have ports C_RDATA (output, 32) and C_RVALID (output, 1), carrying CPU read data and its valid.
REQ-012 SHALL have ports H_REQ, H_ADDR[31:2], H_WDATA[32], H_WSTB[4], H_GNT, H_RDATA[32] and H_RVALID; host (loader/debug) port, same meaning as the CPU port.
REQ-013 SHALL have ports M_CE (output, 1), M_ADDR (output, [31:2]), M_DATAO (output, 32), M_WSTB (output, 4) and M_DATAI (input, 32); this is the dmem port.

Function
REQ-014 SHALL grant at most one requester per cycle; C_GNT and H_GNT are combinational from the requests and the arbiter state.
REQ-015 SHALL grant a lone requester in the same cycle it requests.
REQ-016 On conflict with PRIO_MODE 0, SHALL grant the port not granted last (last-grant register LG: 0 = CPU, 1 = host).
REQ-017 On conflict with PRIO_MODE 1, SHALL grant the CPU unless WCNT == MAX_WAIT, in which case it SHALL grant the host.
REQ-018 LG SHALL update to the granted port on every grant and hold when there is no grant.
REQ-019 WCNT (8-bit) SHALL increment, saturating at MAX_WAIT, while H_REQ & ~H_GNT, and SHALL clear to 0 on H_GNT or ~H_REQ.
REQ-020 M_CE SHALL be C_GNT | H_GNT; M_ADDR, M_DATAO and M_WSTB SHALL be muxed from the granted port, and SHALL be all-zero when nothing is granted.
REQ-021 dmem read latency is 1 cycle: a granted read (WSTB == 0) in cycle N SHALL assert that port's RVALID in cycle N+1 with RDATA = M_DATAI.
REQ-022 Writes SHALL complete on grant and SHALL NOT produce RVALID.
REQ-023 RDATA of a port SHALL be 0 whenever its RVALID is 0.
REQ-024 Back-to-back grants SHALL be sustained: one access per cycle, with no bubble between ports.
REQ-025 A requester SHALL hold REQ, ADDR, WDATA and WSTB stable until granted; the arbiter SHALL NOT latch requests that were not granted.
REQ-026 Read-after-write by the other port to the same address in consecutive cycles SHALL return the new data (dmem ordering; no reordering in the arbiter).

Reset
REQ-027 While RSTN = 0: LG = 1 (CPU wins the first conflict), WCNT = 0, C_RVALID = H_RVALID = 0, C_RDATA = H_RDATA = 0, GNT = 0, M_CE = 0, M_WSTB = 0.
REQ-028 Reset asserted mid-operation SHALL discard any pending RVALID; no RVALID SHALL appear in the first cycle after RSTN rises.

Verification
REQ-029 Reset, then C_REQ read at 0x0010_0000 (dmem preloaded 0xDEADBEEF) -> C_GNT same cycle, C_RVALID = 1 with C_RDATA = 0xDEADBEEF next cycle.
REQ-030 PRIO_MODE 0, both ports request reads continuously -> grants alternate C, H, C, H starting with C; each RVALID follows its grant by 1 cycle.
REQ-031 PRIO_MODE 1, MAX_WAIT = 3, both ports request continuously -> CPU granted 3 cycles, host granted in cycle 4, WCNT returns to 0, pattern repeats.
REQ-032 Host write 0x12345678 with WSTB 1111 at address A in cycle N, CPU read of A in cycle N+1 -> no H_RVALID; C_RDATA = 0x12345678 in cycle N+2.
REQ-033 CPU write with WSTB 0010 -> M_WSTB = 0010, C_RVALID stays 0, C_STALL = 0.
REQ-034 RSTN dropped in the cycle after a host read grant -> H_RVALID stays 0, and all outputs are at reset values until RSTN rises.
